// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, routing in-order responses via an owner-tag FIFO.
// Optional round-robin tie-break with macro SRAM_ARB_RR_EN; default is fixed data-over-inst priority.
module sram_bus_arbiter #(
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [MAX_OUT-1:0] tags;
  logic               winner_d;
  logic               sel_d;
  logic               push;
  logic               pop;
  logic               can_acc;
  logic               head;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;
  // On a tie, whoever did not win the previous accept goes first.
  assign winner_d = data_req & (~inst_req | ~last_grant);
`else
  assign winner_d = data_req;
`endif

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head    = tags[rd_ptr];
  assign pop     = mem_data_ok & (cnt != '0) & ~reset;
  // A full FIFO may still accept when the same cycle's response frees a slot.
  assign can_acc = (cnt != CW'(MAX_OUT)) | pop;

  always_comb begin
    sel_d   = 1'b0;
    mem_req = 1'b0;
    case (state)
      IDLE: begin
        sel_d   = winner_d;
        mem_req = (inst_req | data_req) & can_acc;
      end
      HOLD_I: mem_req = can_acc;
      HOLD_D: begin
        sel_d   = 1'b1;
        mem_req = can_acc;
      end
      default: ;
    endcase
    if (reset) mem_req = 1'b0;
  end

  assign push         = mem_req & mem_addr_ok;
  assign mem_wr       = mem_req & sel_d & data_wr;
  assign mem_wstrb    = (mem_req & sel_d) ? data_wstrb : '0;
  assign mem_wdata    = (mem_req & sel_d) ? data_wdata : '0;
  assign mem_addr     = !mem_req ? '0 : (sel_d ? data_addr : inst_addr);
  assign inst_addr_ok = push & ~sel_d;
  assign data_addr_ok = push & sel_d;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tags   <= '0;
`ifdef SRAM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      if (push) begin
        tags[wr_ptr] <= sel_d;
        wr_ptr       <= ptr_next(wr_ptr);
`ifdef SRAM_ARB_RR_EN
        last_grant   <= sel_d;
`endif
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case (state)
        IDLE:    if (mem_req && !mem_addr_ok) state <= sel_d ? HOLD_D : HOLD_I;
        HOLD_I,
        HOLD_D:  if (push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter (MAX_OUT = 2); expectations follow SRAM_ARB_RR_EN when defined.
module tb_sram_bus_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUT(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inst_req = 1'b1;
    data_req = 1'b1;
    #2;
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passes++;
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0)
      $display("FAIL rst_oks: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passes++;
    checks++; if (dut.cnt !== 2'd0) $display("FAIL rst_cnt: got %0d want 0", dut.cnt); else passes++;
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
    #4;
    checks++; if (inst_addr_ok !== 1'b1) $display("FAIL fetch_aok: got %b want 1", inst_addr_ok); else passes++;
    checks++; if (mem_addr !== 32'h1C00_0000) $display("FAIL fetch_mem_addr: got %h want 1c000000", mem_addr); else passes++;
    checks++; if ({mem_wr, mem_wstrb} !== 5'b0) $display("FAIL fetch_wr_wstrb: got %b want 0", {mem_wr, mem_wstrb}); else passes++;
    checks++; if (data_addr_ok !== 1'b0) $display("FAIL fetch_data_aok: got %b want 0", data_addr_ok); else passes++;
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
    #4;
    checks++; if (inst_data_ok !== 1'b1) $display("FAIL fetch_dok: got %b want 1", inst_data_ok); else passes++;
    checks++; if (inst_rdata !== 32'h0280_0C0C) $display("FAIL fetch_rdata: got %h want 02800c0c", inst_rdata); else passes++;
    checks++; if (data_data_ok !== 1'b0) $display("FAIL fetch_data_dok: got %b want 0", data_data_ok); else passes++;
    tick();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_tie_and_full();
    inst_req = 1'b1; inst_addr = 32'h100;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h800; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1'b1;
    #4;
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0)
      $display("FAIL tie1_grant: got d=%b i=%b want d=1 i=0", data_addr_ok, inst_addr_ok); else passes++;
    checks++; if ({mem_wr, mem_wstrb, mem_addr} !== {1'b1, 4'hF, 32'h800})
      $display("FAIL tie1_mem: got wr=%b strb=%h addr=%h want 1 f 800", mem_wr, mem_wstrb, mem_addr); else passes++;
    tick();
    data_addr = 32'h804;
    #4;
    checks++; if (inst_addr_ok !== RR || data_addr_ok !== !RR)
      $display("FAIL tie2_grant: got i=%b d=%b want i=%b d=%b", inst_addr_ok, data_addr_ok, RR, !RR); else passes++;
    checks++; if (mem_addr !== (RR ? 32'h100 : 32'h804))
      $display("FAIL tie2_mem_addr: got %h want %h", mem_addr, RR ? 32'h100 : 32'h804); else passes++;
    tick();
    inst_req = !RR; data_req = RR;
    #4;
    checks++; if (mem_req !== 1'b0) $display("FAIL full_mem_req: got %b want 0", mem_req); else passes++;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00)
      $display("FAIL full_aok: got %b want 00", {inst_addr_ok, data_addr_ok}); else passes++;
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_AAAA;
    #4;
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
      $display("FAIL full_pop: got d=%b i=%b want d=1 i=0", data_data_ok, inst_data_ok); else passes++;
    checks++; if (inst_addr_ok !== !RR || data_addr_ok !== RR)
      $display("FAIL full_accept: got i=%b d=%b want i=%b d=%b", inst_addr_ok, data_addr_ok, !RR, RR); else passes++;
    tick();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #4;
    checks++; if (dut.cnt !== 2'd2) $display("FAIL full_cnt: got %0d want 2", dut.cnt); else passes++;
    tick();
    mem_data_ok = 1'b1;
    #4;
    checks++; if (inst_data_ok !== RR || data_data_ok !== !RR)
      $display("FAIL drain2: got i=%b d=%b want i=%b d=%b", inst_data_ok, data_data_ok, RR, !RR); else passes++;
    tick();
    #4;
    checks++; if (inst_data_ok !== !RR || data_data_ok !== RR)
      $display("FAIL drain3: got i=%b d=%b want i=%b d=%b", inst_data_ok, data_data_ok, !RR, RR); else passes++;
    tick();
    mem_data_ok = 1'b0;
    #4;
    checks++; if (dut.cnt !== 2'd0) $display("FAIL drain_cnt: got %0d want 0", dut.cnt); else passes++;
  endtask

  task automatic test_backpressure();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h900; mem_addr_ok = 1'b0;
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h900 || data_addr_ok !== 1'b0)
      $display("FAIL bp_c0: got req=%b addr=%h aok=%b want 1 900 0", mem_req, mem_addr, data_addr_ok); else passes++;
    tick();
    inst_req = 1'b1; inst_addr = 32'h200;
    #4;
    checks++; if (mem_addr !== 32'h900 || inst_addr_ok !== 1'b0)
      $display("FAIL bp_c1: got addr=%h iaok=%b want 900 0", mem_addr, inst_addr_ok); else passes++;
    tick();
    #4;
    checks++; if (mem_addr !== 32'h900) $display("FAIL bp_c2: got %h want 900", mem_addr); else passes++;
    tick();
    mem_addr_ok = 1'b1;
    #4;
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || mem_addr !== 32'h900)
      $display("FAIL bp_c3: got d=%b i=%b addr=%h want 1 0 900", data_addr_ok, inst_addr_ok, mem_addr); else passes++;
    tick();
    data_req = 1'b0;
    #4;
    checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h200)
      $display("FAIL bp_inst: got aok=%b addr=%h want 1 200", inst_addr_ok, mem_addr); else passes++;
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick();
    tick();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_ordering();
    inst_req = 1'b1; inst_addr = 32'h400; mem_addr_ok = 1'b1;
    #4;
    checks++; if (inst_addr_ok !== 1'b1) $display("FAIL ord_iaok: got %b want 1", inst_addr_ok); else passes++;
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h500;
    #4;
    checks++; if (data_addr_ok !== 1'b1) $display("FAIL ord_daok: got %b want 1", data_addr_ok); else passes++;
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11;
    #4;
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h11)
      $display("FAIL ord_first: got i=%b d=%b rd=%h want 1 0 11", inst_data_ok, data_data_ok, inst_rdata); else passes++;
    tick();
    mem_rdata = 32'h22;
    #4;
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'h22)
      $display("FAIL ord_second: got d=%b i=%b rd=%h want 1 0 22", data_data_ok, inst_data_ok, data_rdata); else passes++;
    tick();
    #4;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00)
      $display("FAIL spurious: got %b want 00", {inst_data_ok, data_data_ok}); else passes++;
    tick();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid();
    inst_req = 1'b1; inst_addr = 32'h300; mem_addr_ok = 1'b1;
    tick();
    inst_addr = 32'h304; mem_addr_ok = 1'b0;
    tick();
    reset = 1'b1; inst_req = 1'b0;
    #1;
    checks++; if (dut.cnt !== 2'd0 || mem_req !== 1'b0)
      $display("FAIL midrst_async: got cnt=%0d req=%b want 0 0", dut.cnt, mem_req); else passes++;
    tick();
    reset = 1'b0;
    data_req = 1'b1; data_addr = 32'hA00; mem_data_ok = 1'b1;
    #4;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00)
      $display("FAIL midrst_dok: got %b want 00", {inst_data_ok, data_data_ok}); else passes++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hA00)
      $display("FAIL midrst_idle: got req=%b addr=%h want 1 a00", mem_req, mem_addr); else passes++;
    tick();
    data_req = 1'b0; mem_data_ok = 1'b0;
    #4;
    checks++; if (dut.cnt !== 2'd0) $display("FAIL midrst_cnt: got %0d want 0", dut.cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie_and_full();
    test_backpressure();
    test_ordering();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
